pipe_skid_reg: RTL

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

---
 rtl/pipe_skid_reg_pkg.sv | 14 +
 rtl/pipe_skid_reg_sat_counter.sv | 31 +++
 rtl/pipe_skid_reg.sv | 108 ++++++++++
 3 files changed

// File: rtl/pipe_skid_reg_pkg.sv
// Shared pipeline package: skid-stage state encoding and default parameters.
package pipe_skid_reg_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_CNT_WIDTH  = 16;
  localparam int DEF_CLEAR_DATA = 1;

endpackage

// File: rtl/pipe_skid_reg_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones.
module pipe_skid_reg_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (inc && (count_reg != {WIDTH{1'b1}})) begin
      count_next = count_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry skid-buffer pipeline register with registered in_ready,
// synchronous flush and a saturating backpressure counter.
module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
  parameter int CLEAR_DATA = DEF_CLEAR_DATA
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0]  stall_cnt
);

  skid_state_e           state_reg;
  skid_state_e           state_next;
  logic [DATA_WIDTH-1:0] main_reg;
  logic [DATA_WIDTH-1:0] main_next;
  logic [DATA_WIDTH-1:0] skid_reg;
  logic [DATA_WIDTH-1:0] skid_next;
  logic                  in_ready_reg;
  logic                  in_ready_next;
  logic                  in_fire;

  // in_ready_reg is low during and just after reset, so gating on it keeps
  // the first post-reset edge from accepting a beat.
  assign in_fire = in_valid & in_ready_reg;

  always_comb begin
    state_next = state_reg;
    main_next  = main_reg;
    skid_next  = skid_reg;

    if (flush) begin
      state_next = ST_EMPTY;
      if (CLEAR_DATA != 0) begin
        main_next = '0;
        skid_next = '0;
      end
    end else begin
      case (state_reg)
        ST_EMPTY: begin
          if (in_fire) begin
            state_next = ST_ONE;
            main_next  = in_data;
          end
        end
        ST_ONE: begin
          if (in_fire && out_ready) begin
            main_next = in_data;
          end else if (in_fire) begin
            state_next = ST_FULL;
            skid_next  = in_data;
          end else if (out_ready) begin
            state_next = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_ready) begin
            state_next = ST_ONE;
            main_next  = skid_reg;
          end
        end
        default: begin
          state_next = ST_EMPTY;
        end
      endcase
    end

    // Looking at the next state keeps out_ready off any combinational path to in_ready.
    in_ready_next = (state_next != ST_FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_EMPTY;
      main_reg     <= '0;
      skid_reg     <= '0;
      in_ready_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      main_reg     <= main_next;
      skid_reg     <= skid_next;
      in_ready_reg <= in_ready_next;
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = (state_reg != ST_EMPTY);
  assign out_data  = main_reg;

  pipe_skid_reg_sat_counter #(
    .WIDTH(CNT_WIDTH)
  ) u_stall_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (out_valid & ~out_ready),
    .count(stall_cnt)
  );

endmodule
